// File: rtl/atmega_pio_rmw_arbiter_pkg.sv
// Shared definitions for the atmega PIO read-modify-write arbiter.
//   op_e    : requester operation codes (2 bits per requester on req_op)
//   state_e : bus-sequencer FSM states
package atmega_pio_rmw_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_SET   = 2'b10,
    OP_CLR   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/atmega_rr_arbiter.sv
// Combinational round-robin pick.
//   req        : pending request vector
//   last_grant : index served most recently
//   valid      : at least one request pending
//   index      : first set request found searching upward from last_grant+1,
//                wrapping modulo NUM_REQ
module atmega_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest pending request,
  // being assigned last, is the one that sticks.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/atmega_pio_rmw_arbiter.sv
// Shares one atmega PIO register bus between NUM_REQ requesters.
// Each grant runs atomically to completion: WRITE, READ, or a read-modify-write
// bit SET/CLR that is never interleaved with another requester's access.
//   clk, rst     : clock; asynchronous active-low reset
//   req          : per-requester request, held until its own ack
//   req_op       : per-requester op (2 bits each)
//   req_addr     : per-requester register address
//   req_data     : WRITE data or SET/CLR bit mask
//   ack          : one-cycle, one-hot completion pulse
//   rdata        : READ result / RMW pre-modify value, valid with ack
//   pio_addr     : PIO register address, driven during strobes only
//   pio_wr/pio_rd: PIO strobes, decoded from the state register
//   pio_bus_in   : PIO write data, zero when pio_wr is low
//   pio_bus_out  : PIO combinational read data
module atmega_pio_rmw_arbiter
  import atmega_pio_rmw_arbiter_pkg::*;
#(
  parameter int NUM_REQ           = 2,
  parameter int BUS_ADDR_DATA_LEN = 8,
  parameter int PORT_WIDTH        = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req,
  input  logic [2*NUM_REQ-1:0]                   req_op,
  input  logic [NUM_REQ*BUS_ADDR_DATA_LEN-1:0]   req_addr,
  input  logic [NUM_REQ*PORT_WIDTH-1:0]          req_data,
  output logic [NUM_REQ-1:0]                     ack,
  output logic [PORT_WIDTH-1:0]                  rdata,
  output logic [BUS_ADDR_DATA_LEN-1:0]           pio_addr,
  output logic                                   pio_wr,
  output logic                                   pio_rd,
  output logic [PORT_WIDTH-1:0]                  pio_bus_in,
  input  logic [PORT_WIDTH-1:0]                  pio_bus_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                         state_q, state_d;
  // grant_q is both the current grant and the round-robin "last served" pointer;
  // resetting it to NUM_REQ-1 makes requester 0 win the first arbitration.
  logic [IDX_W-1:0]               grant_q;
  op_e                            op_q;
  logic [BUS_ADDR_DATA_LEN-1:0]   addr_q;
  logic [PORT_WIDTH-1:0]          data_q;
  logic [PORT_WIDTH-1:0]          rd_val_q;

  logic                           arb_valid;
  logic [IDX_W-1:0]               arb_index;
  op_e                            sel_op;
  logic [BUS_ADDR_DATA_LEN-1:0]   sel_addr;
  logic [PORT_WIDTH-1:0]          sel_data;
  logic                           take;

  function automatic logic [PORT_WIDTH-1:0] write_value(
    input op_e                   op,
    input logic [PORT_WIDTH-1:0] data,
    input logic [PORT_WIDTH-1:0] rd_val
  );
    case (op)
      OP_SET:  write_value = rd_val | data;
      OP_CLR:  write_value = rd_val & ~data;
      default: write_value = data;
    endcase
  endfunction

  atmega_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req),
    .last_grant (grant_q),
    .valid      (arb_valid),
    .index      (arb_index)
  );

  // Request fields of the winning requester.
  always_comb begin
    sel_op   = OP_WRITE;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_index == IDX_W'(i)) begin
        sel_op   = op_e'(req_op[2*i +: 2]);
        sel_addr = req_addr[BUS_ADDR_DATA_LEN*i +: BUS_ADDR_DATA_LEN];
        sel_data = req_data[PORT_WIDTH*i +: PORT_WIDTH];
      end
    end
  end

  assign take = (state_q == ST_IDLE) && arb_valid;

  // Control state: FSM, grant pointer, latched op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= IDX_W'(NUM_REQ - 1);
      op_q    <= OP_WRITE;
    end else begin
      state_q <= state_d;
      if (take) begin
        grant_q <= arb_index;
        op_q    <= sel_op;
      end
    end
  end

  // Datapath: latched address/data and read capture; outputs are gated by
  // state, so these need no reset. rd_val is cleared on grant so a WRITE
  // acknowledges with rdata = 0.
  always_ff @(posedge clk) begin
    if (take) begin
      addr_q   <= sel_addr;
      data_q   <= sel_data;
      rd_val_q <= '0;
    end else if (state_q == ST_RD) begin
      rd_val_q <= pio_bus_out;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (arb_valid) state_d = (sel_op == OP_WRITE) ? ST_WR : ST_RD;
      ST_RD:   state_d = (op_q == OP_READ) ? ST_DONE : ST_WR;
      ST_WR:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pio_rd     = (state_q == ST_RD);
    pio_wr     = (state_q == ST_WR);
    pio_addr   = (pio_rd || pio_wr) ? addr_q : '0;
    pio_bus_in = pio_wr ? write_value(op_q, data_q, rd_val_q) : '0;
    rdata      = (state_q == ST_DONE) ? rd_val_q : '0;
    ack        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i] = (state_q == ST_DONE) && (grant_q == IDX_W'(i));
    end
  end

endmodule

// File: tb/tb_atmega_pio_rmw_arbiter.sv
// Bench for atmega_pio_rmw_arbiter: directed scenarios followed by randomized
// traffic, every bus cycle checked against a transaction-level reference.
module tb_atmega_pio_rmw_arbiter;

  localparam int N = 3;
  localparam logic [1:0] W = 2'b00, R = 2'b01, S = 2'b10, C = 2'b11;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [2*N-1:0]   req_op;
  logic [8*N-1:0]   req_addr;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     ack;
  logic [7:0]       rdata;
  logic [7:0]       pio_addr;
  logic             pio_wr;
  logic             pio_rd;
  logic [7:0]       pio_bus_in;
  logic [7:0]       pio_bus_out;

  // PIO register file environment with a backdoor loader.
  logic [7:0]       pio_mem [256];
  logic             poke_en;
  logic [7:0]       poke_addr, poke_val;

  // Reference model state.
  logic [7:0]       ref_mem [256];
  int               ref_last;
  logic [N-1:0]     hold;
  bit               rnd_on;

  int vectors, miscompares;

  atmega_pio_rmw_arbiter #(
    .NUM_REQ           (N),
    .BUS_ADDR_DATA_LEN (8),
    .PORT_WIDTH        (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .ack         (ack),
    .rdata       (rdata),
    .pio_addr    (pio_addr),
    .pio_wr      (pio_wr),
    .pio_rd      (pio_rd),
    .pio_bus_in  (pio_bus_in),
    .pio_bus_out (pio_bus_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign pio_bus_out = pio_mem[pio_addr];

  always @(posedge clk) begin
    if (pio_wr) pio_mem[pio_addr] <= pio_bus_in;
    else if (poke_en) pio_mem[poke_addr] <= poke_val;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(input string tag, input logic rd, input logic wr,
                           input logic [7:0] a, input logic [7:0] bi,
                           input logic [N-1:0] ak, input logic [7:0] rv);
    chk({tag, ".pio_rd"}, 32'(pio_rd), 32'(rd));
    chk({tag, ".pio_wr"}, 32'(pio_wr), 32'(wr));
    chk({tag, ".pio_addr"}, 32'(pio_addr), 32'(a));
    chk({tag, ".pio_bus_in"}, 32'(pio_bus_in), 32'(bi));
    chk({tag, ".ack"}, 32'(ack), 32'(ak));
    chk({tag, ".rdata"}, 32'(rdata), 32'(rv));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    req_op[2*i +: 2]   = op;
    req_addr[8*i +: 8] = a;
    req_data[8*i +: 8] = d;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    set_fields(i, op, a, d);
    req[i] = 1'b1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    poke_en = 1'b1;
    poke_addr = a;
    poke_val = v;
    ref_mem[a] = v;
    tick();
    poke_en = 1'b0;
  endtask

  // Disturb requester inputs while a transaction is in flight: the granted
  // requester's fields change (must be ignored) and others may raise requests.
  task automatic mid_traffic(input int w);
    if (!rnd_on) return;
    if ($urandom_range(0, 1) == 0)
      set_fields(w, 2'($urandom_range(0, 3)), 8'h20 + 8'($urandom_range(0, 7)), 8'($urandom));
    for (int i = 0; i < N; i++) begin
      if (i != w && !req[i] && $urandom_range(0, 3) == 0) begin
        hold[i] = 1'b0;
        set_req(i, 2'($urandom_range(0, 3)), 8'h20 + 8'($urandom_range(0, 7)), 8'($urandom));
      end
    end
  endtask

  // Called in an IDLE cycle with inputs already set for the next edge.
  // Predicts the winner and its complete bus sequence, checking each cycle.
  task automatic serve();
    int w;
    logic [1:0] op;
    logic [7:0] a, d, old, nv;
    chk_cycle("idle", 0, 0, 8'h00, 8'h00, '0, 8'h00);
    w = -1;
    for (int k = N; k >= 1; k--) begin
      if (req[(ref_last + k) % N]) w = (ref_last + k) % N;
    end
    if (w < 0) begin
      tick();
      return;
    end
    op = req_op[2*w +: 2];
    a  = req_addr[8*w +: 8];
    d  = req_data[8*w +: 8];
    old = ref_mem[a];
    ref_last = w;
    tick();
    mid_traffic(w);
    case (op)
      W: begin
        chk_cycle("write", 0, 1, a, d, '0, 8'h00);
        ref_mem[a] = d;
      end
      R: chk_cycle("read", 1, 0, a, 8'h00, '0, 8'h00);
      default: begin
        chk_cycle("rmw_rd", 1, 0, a, 8'h00, '0, 8'h00);
        tick();
        mid_traffic(w);
        nv = (op == S) ? (old | d) : (old & ~d);
        chk_cycle("rmw_wr", 0, 1, a, nv, '0, 8'h00);
        ref_mem[a] = nv;
      end
    endcase
    tick();
    chk_cycle("done", 0, 0, 8'h00, 8'h00, N'(1 << w), (op == W) ? 8'h00 : old);
    if (!hold[w]) req[w] = 1'b0;
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    req = '0;
    req_op = '0;
    req_addr = '0;
    req_data = '0;
    poke_en = 1'b0;
    poke_addr = '0;
    poke_val = '0;
    hold = '0;
    rnd_on = 1'b0;
    ref_last = N - 1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    // Reset state.
    tick();
    tick();
    chk_cycle("reset", 0, 0, 8'h00, 8'h00, '0, 8'h00);
    #3 rst = 1'b1;
    for (int i = 0; i < 8; i++) poke(8'h20 + 8'(i), 8'($urandom));

    // 1: WRITE 0xFF to 0x23 from requester 0.
    poke(8'h23, 8'h00);
    set_req(0, W, 8'h23, 8'hFF);
    serve();
    chk("t1_port", 32'(pio_mem[8'h23]), 32'h0000_00FF);

    // 2: SET mask 0x30 on PORT=0x0F from requester 1.
    poke(8'h20, 8'h0F);
    set_req(1, S, 8'h20, 8'h30);
    serve();
    chk("t2_port", 32'(pio_mem[8'h20]), 32'h0000_003F);

    // 5: READ returning 0xA5.
    poke(8'h24, 8'hA5);
    set_req(0, R, 8'h24, 8'h00);
    serve();

    // 3: two continuously held requesters alternate.
    hold[0] = 1'b1;
    hold[1] = 1'b1;
    set_req(0, W, 8'h25, 8'h11);
    set_req(1, W, 8'h26, 8'h22);
    for (int i = 0; i < 5; i++) serve();
    hold = '0;
    req = '0;

    // 4: CLR from requester 0 runs back-to-back ahead of a pending WRITE.
    poke(8'h21, 8'hFF);
    set_req(0, C, 8'h21, 8'h01);
    set_req(1, W, 8'h22, 8'h5A);
    serve();
    serve();
    chk("t4_port", 32'(pio_mem[8'h21]), 32'h0000_00FE);

    // Zero masks still do read then write of the unchanged value; idle cycle.
    set_req(1, S, 8'h20, 8'h00);
    serve();
    set_req(0, C, 8'h21, 8'h00);
    serve();
    serve();

    // 6: reset during the read phase of a SET.
    set_req(1, S, 8'h22, 8'h80);
    tick();
    chk_cycle("t6_rd", 1, 0, 8'h22, 8'h00, '0, 8'h00);
    #3 rst = 1'b0;
    #1 chk_cycle("t6_rst", 0, 0, 8'h00, 8'h00, '0, 8'h00);
    set_req(0, S, 8'h22, 8'h01);
    tick();
    chk_cycle("t6_held", 0, 0, 8'h00, 8'h00, '0, 8'h00);
    #4 rst = 1'b1;
    ref_last = N - 1;
    serve();
    serve();
    chk("t6_port", 32'(pio_mem[8'h22]), 32'h0000_00DB);

    // Randomized traffic.
    rnd_on = 1'b1;
    for (int it = 0; it < 150; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 0) begin
          hold[i] = ($urandom_range(0, 4) == 0);
          set_req(i, 2'($urandom_range(0, 3)), 8'h20 + 8'($urandom_range(0, 7)), 8'($urandom));
        end
      end
      serve();
    end
    rnd_on = 1'b0;
    hold = '0;
    for (int i = 0; i < 4 * N && req != '0; i++) serve();
    for (int i = 0; i < 8; i++)
      chk("final_mem", 32'(pio_mem[8'h20 + 8'(i)]), 32'(ref_mem[8'h20 + 8'(i)]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
